// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle arithmetic/logic ops plus SLL/SRL/SRA on a shared 1-bit shifter.
// Latency: non-shift (or shamt=0) result valid the cycle after accept; shifts valid shamt cycles after accept.
// Backpressure: o_ready only in IDLE; result held in DONE (o_valid=1) until i_ready, inputs ignored meanwhile.
module alu_exec_unit #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CTRL_W-1:0] i_alu_control,
  input  logic [DATA_W-1:0] i_operand_a,
  input  logic [DATA_W-1:0] i_operand_b,
  input  logic [4:0]        i_shamt,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero
);

  // alu_control encodings; codes outside this set execute as ADD
  localparam logic [CTRL_W-1:0] ALU_AND    = 4'h0;
  localparam logic [CTRL_W-1:0] ALU_OR     = 4'h1;
  localparam logic [CTRL_W-1:0] ALU_ADD    = 4'h2;
  localparam logic [CTRL_W-1:0] ALU_XOR    = 4'h3;
  localparam logic [CTRL_W-1:0] ALU_NOR    = 4'h4;
  localparam logic [CTRL_W-1:0] ALU_SLTU   = 4'h5;
  localparam logic [CTRL_W-1:0] ALU_SUB    = 4'h6;
  localparam logic [CTRL_W-1:0] ALU_SLT    = 4'h7;
  localparam logic [CTRL_W-1:0] ALU_SLL    = 4'h8;
  localparam logic [CTRL_W-1:0] ALU_SRL    = 4'h9;
  localparam logic [CTRL_W-1:0] ALU_SRA    = 4'hA;
  localparam logic [CTRL_W-1:0] ALU_LUI    = 4'hB;
  localparam logic [CTRL_W-1:0] ALU_BYPASS = 4'hC;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] work_q, work_d;   // shift working register, doubles as the result register
  logic [4:0]        cnt_q, cnt_d;     // shifts still to perform while BUSY
  logic [CTRL_W-1:0] kind_q, kind_d;   // latched op code for the shift direction

  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] shift_src;
  logic [DATA_W-1:0] shifted;
  logic [CTRL_W-1:0] shift_kind;
  logic              is_shift;

  // single-cycle ALU result from the live request operands
  always_comb begin
    alu_res = i_operand_a + i_operand_b;
    case (i_alu_control)
      ALU_AND:    alu_res = i_operand_a & i_operand_b;
      ALU_OR:     alu_res = i_operand_a | i_operand_b;
      ALU_XOR:    alu_res = i_operand_a ^ i_operand_b;
      ALU_NOR:    alu_res = ~(i_operand_a | i_operand_b);
      ALU_SUB:    alu_res = i_operand_a - i_operand_b;
      ALU_SLT:    alu_res = {{(DATA_W-1){1'b0}}, ($signed(i_operand_a) < $signed(i_operand_b))};
      ALU_SLTU:   alu_res = {{(DATA_W-1){1'b0}}, (i_operand_a < i_operand_b)};
      ALU_LUI:    alu_res = i_operand_b << 16;
      ALU_BYPASS: alu_res = i_operand_a;
      default:    alu_res = i_operand_a + i_operand_b;
    endcase
  end

  // shared 1-bit shifter: fed by operand B on the accept edge, by the working register while BUSY
  always_comb begin
    shift_src  = (state_q == S_IDLE) ? i_operand_b : work_q;
    shift_kind = (state_q == S_IDLE) ? i_alu_control : kind_q;
    case (shift_kind)
      ALU_SRL: shifted = {1'b0, shift_src[DATA_W-1:1]};
      ALU_SRA: shifted = {shift_src[DATA_W-1], shift_src[DATA_W-1:1]};
      default: shifted = {shift_src[DATA_W-2:0], 1'b0};
    endcase
  end

  assign is_shift = (i_alu_control == ALU_SLL) || (i_alu_control == ALU_SRL) ||
                    (i_alu_control == ALU_SRA);

  // next-state: the accept edge performs the first shift so the result lands shamt cycles later
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          kind_d = i_alu_control;
          if (!is_shift) begin
            work_d  = alu_res;
            state_d = S_DONE;
          end else if (i_shamt == 5'd0) begin
            work_d  = i_operand_b;
            state_d = S_DONE;
          end else begin
            work_d  = shifted;
            cnt_d   = i_shamt - 5'd1;
            state_d = (i_shamt == 5'd1) ? S_DONE : S_BUSY;
          end
        end
      end
      S_BUSY: begin
        work_d = shifted;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = S_DONE;
      end
      S_DONE: begin
        if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      kind_q  <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
    end
  end

  assign o_ready  = (state_q == S_IDLE);
  assign o_valid  = (state_q == S_DONE);
  assign o_result = work_q;
  assign o_zero   = (work_q == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: reset, arithmetic, shifts, latency and backpressure.
// Expected values are hand-computed constants.
// Inputs driven on falling edges, outputs sampled on falling edges.
module tb_alu_exec_unit;

  localparam logic [3:0] C_AND = 4'h0, C_OR = 4'h1, C_ADD = 4'h2, C_XOR = 4'h3, C_NOR = 4'h4,
                         C_SLTU = 4'h5, C_SUB = 4'h6, C_SLT = 4'h7, C_SLL = 4'h8, C_SRL = 4'h9,
                         C_SRA = 4'hA, C_LUI = 4'hB, C_BYP = 4'hC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [3:0]  i_alu_control;
  logic [31:0] i_operand_a;
  logic [31:0] i_operand_b;
  logic [4:0]  i_shamt;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_zero;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.DATA_W(32), .CTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_alu_control(i_alu_control), .i_operand_a(i_operand_a), .i_operand_b(i_operand_b),
    .i_shamt(i_shamt), .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_zero(o_zero)
  );

  // present one request while the unit is idle, then count cycles until o_valid (-1 on timeout)
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output int lat, output logic [31:0] res,
                       output logic z);
    logic seen;
    @(negedge clk);
    i_valid = 1'b1; i_alu_control = c; i_operand_a = a; i_operand_b = b; i_shamt = sh;
    @(posedge clk);
    #1 i_valid = 1'b0;
    lat = -1; seen = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (!seen) begin
        @(negedge clk);
        if (o_valid) begin lat = k; seen = 1'b1; end
      end
    end
    res = o_result; z = o_zero;
  endtask

  task automatic consume();
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk);
    #1 i_ready = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", o_valid); end
    n_cmp++; if (o_result !== 32'h0) begin n_err++; $display("FAIL reset_result got %h want 00000000", o_result); end
    n_cmp++; if (o_zero !== 1'b1) begin n_err++; $display("FAIL reset_zero got %b want 1", o_zero); end
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", o_ready); end
    // abort an SRA by 20 part way through
    @(negedge clk);
    i_valid = 1'b1; i_alu_control = C_SRA; i_operand_b = 32'h80000000; i_shamt = 5'd20;
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL midshift_busy ready got %b want 0", o_ready); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid got %b want 0", o_valid); end
    n_cmp++; if (o_result !== 32'h0) begin n_err++; $display("FAIL abort_result got %h want 00000000", o_result); end
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready got %b want 1", o_ready); end
    rst_n = 1'b1;
    bad = 0;
    repeat (25) begin
      @(negedge clk);
      if (o_valid !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL abort_no_result valid cycles got %0d want 0", bad); end
  endtask

  task automatic test_add_sub();
    int lat; logic [31:0] r; logic z;
    issue(C_ADD, 32'h7FFFFFFF, 32'h1, 5'd0, lat, r, z);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL add_latency got %0d want 1", lat); end
    n_cmp++; if (r !== 32'h80000000) begin n_err++; $display("FAIL add_result got %h want 80000000", r); end
    n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL add_zero got %b want 0", z); end
    consume();
    issue(C_SUB, 32'd5, 32'd5, 5'd0, lat, r, z);
    n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL sub_result got %h want 00000000", r); end
    n_cmp++; if (z !== 1'b1) begin n_err++; $display("FAIL sub_zero got %b want 1", z); end
    consume();
  endtask

  task automatic test_shift();
    int lat; logic [31:0] r; logic z;
    issue(C_SRA, 32'h0, 32'h80000000, 5'd31, lat, r, z);
    n_cmp++; if (lat !== 31) begin n_err++; $display("FAIL sra31_latency got %0d want 31", lat); end
    n_cmp++; if (r !== 32'hFFFFFFFF) begin n_err++; $display("FAIL sra31_result got %h want ffffffff", r); end
    consume();
    issue(C_SRL, 32'h0, 32'h80000000, 5'd31, lat, r, z);
    n_cmp++; if (lat !== 31) begin n_err++; $display("FAIL srl31_latency got %0d want 31", lat); end
    n_cmp++; if (r !== 32'h00000001) begin n_err++; $display("FAIL srl31_result got %h want 00000001", r); end
    consume();
    issue(C_SLL, 32'h0, 32'h0000000F, 5'd4, lat, r, z);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL sll4_latency got %0d want 4", lat); end
    n_cmp++; if (r !== 32'h000000F0) begin n_err++; $display("FAIL sll4_result got %h want 000000f0", r); end
    consume();
    issue(C_SRA, 32'h0, 32'h7FFF0000, 5'd8, lat, r, z);
    n_cmp++; if (r !== 32'h007FFF00) begin n_err++; $display("FAIL sra8_pos_result got %h want 007fff00", r); end
    consume();
  endtask

  task automatic test_slt_sll0();
    int lat; logic [31:0] r; logic z;
    issue(C_SLL, 32'h0, 32'h0000000F, 5'd0, lat, r, z);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL sll0_latency got %0d want 1", lat); end
    n_cmp++; if (r !== 32'h0000000F) begin n_err++; $display("FAIL sll0_result got %h want 0000000f", r); end
    consume();
    issue(C_SLT, 32'hFFFFFFFF, 32'h1, 5'd0, lat, r, z);
    n_cmp++; if (r !== 32'h1) begin n_err++; $display("FAIL slt_result got %h want 00000001", r); end
    consume();
    issue(C_SLTU, 32'hFFFFFFFF, 32'h1, 5'd0, lat, r, z);
    n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL sltu_result got %h want 00000000", r); end
    consume();
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] r; logic z;
    int bad;
    issue(C_XOR, 32'hF0F0F0F0, 32'h0F0F0F00, 5'd0, lat, r, z);
    n_cmp++; if (r !== 32'hFFFFFFF0) begin n_err++; $display("FAIL xor_result got %h want fffffff0", r); end
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      i_valid = 1'b1; i_alu_control = C_ADD; i_operand_a = 32'h11111111 * (k + 1);
      i_operand_b = 32'h0; i_shamt = 5'd3;
      @(negedge clk);
      if (o_result !== 32'hFFFFFFF0 || o_valid !== 1'b1 || o_ready !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL hold_stable bad cycles got %0d want 0", bad); end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL release_ready got %b want 1", o_ready); end
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL release_valid got %b want 0", o_valid); end
  endtask

  task automatic test_misc_ops();
    int lat; logic [31:0] r; logic z;
    issue(C_LUI, 32'h0, 32'h00001234, 5'd0, lat, r, z);
    n_cmp++; if (r !== 32'h12340000) begin n_err++; $display("FAIL lui_result got %h want 12340000", r); end
    consume();
    issue(C_BYP, 32'h00400008, 32'hDEADBEEF, 5'd0, lat, r, z);
    n_cmp++; if (r !== 32'h00400008) begin n_err++; $display("FAIL bypass_result got %h want 00400008", r); end
    consume();
    issue(4'hF, 32'd2, 32'd3, 5'd0, lat, r, z);
    n_cmp++; if (r !== 32'd5) begin n_err++; $display("FAIL undef_code_result got %h want 00000005", r); end
    consume();
    issue(C_NOR, 32'hF0F00000, 32'h0000F0F0, 5'd0, lat, r, z);
    n_cmp++; if (r !== 32'h0F0F0F0F) begin n_err++; $display("FAIL nor_result got %h want 0f0f0f0f", r); end
    consume();
    issue(C_AND, 32'hFF00FF00, 32'h0FF00FF0, 5'd0, lat, r, z);
    n_cmp++; if (r !== 32'h0F000F00) begin n_err++; $display("FAIL and_result got %h want 0f000f00", r); end
    consume();
    issue(C_OR, 32'hFF000000, 32'h000000FF, 5'd0, lat, r, z);
    n_cmp++; if (r !== 32'hFF0000FF) begin n_err++; $display("FAIL or_result got %h want ff0000ff", r); end
    consume();
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_alu_control = 4'h0; i_operand_a = '0; i_operand_b = '0; i_shamt = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_add_sub();
    test_shift();
    test_slt_sll0();
    test_backpressure();
    test_misc_ops();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
